// File: rtl/riscv_core_irq_ctrl.sv
// External interrupt controller driving the core's machine-external interrupt line.
// Level sources latch into pending bits; fixed-priority claim, CSR ack, then software completion.
module riscv_core_irq_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic             i_irq_ctrl_clk,
    input  logic             i_irq_ctrl_rst,
    input  logic [N_SRC-1:0] i_irq_ctrl_src,
    input  logic             i_irq_ctrl_wen,
    input  logic [1:0]       i_irq_ctrl_addr,
    input  logic [63:0]      i_irq_ctrl_wdata,
    output logic [63:0]      o_irq_ctrl_rdata,
    output logic             o_irq_ctrl_mexternal,
    input  logic             i_irq_ctrl_ack,
    output logic [ID_W-1:0]  o_irq_ctrl_claim_id
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [N_SRC-1:0] r_src_q;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_inservice;
    logic [ID_W-1:0]  r_claim_id;
    logic             r_mext;

    logic [N_SRC-1:0] w_cand;
    logic [N_SRC-1:0] w_claim_mask;
    logic [ID_W-1:0]  w_win_id;
    logic             w_claim;
    logic             w_ack;
    logic             w_complete;
    logic             w_en_wr;
    logic             w_unused_wdata;

    assign w_cand     = r_pending & r_enable & ~r_inservice;
    assign w_en_wr    = i_irq_ctrl_wen && (i_irq_ctrl_addr == 2'd1);
    assign w_claim    = (r_state == S_IDLE) && (|w_cand);
    assign w_ack      = (r_state == S_REQ) && i_irq_ctrl_ack;
    assign w_complete = (r_state == S_SERVICE) && i_irq_ctrl_wen &&
                        (i_irq_ctrl_addr == 2'd2) &&
                        (i_irq_ctrl_wdata[ID_W-1:0] == r_claim_id);

    // Only the low bits of a write carry meaning.
    assign w_unused_wdata = ^i_irq_ctrl_wdata;

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        w_win_id = '0;
        for (int s = N_SRC - 1; s >= 0; s--) begin
            if (w_cand[s]) begin
                w_win_id = ID_W'(s + 1);
            end
        end
    end

    always_comb begin
        w_claim_mask = '0;
        for (int s = 0; s < N_SRC; s++) begin
            w_claim_mask[s] = (r_claim_id == ID_W'(s + 1));
        end
    end

    always_ff @(posedge i_irq_ctrl_clk or posedge i_irq_ctrl_rst) begin
        if (i_irq_ctrl_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|w_cand) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (i_irq_ctrl_ack) begin
                    w_state_nxt = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (w_complete) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_irq_ctrl_clk or posedge i_irq_ctrl_rst) begin
        if (i_irq_ctrl_rst) begin
            r_src_q     <= '0;
            r_pending   <= '0;
            r_enable    <= '0;
            r_inservice <= '0;
            r_claim_id  <= '0;
            r_mext      <= 1'b0;
        end else begin
            r_src_q   <= i_irq_ctrl_src;
            // A claim clear beats a same-cycle set.
            r_pending <= (r_pending | (r_src_q & ~r_inservice)) &
                         ~(w_ack ? w_claim_mask : '0);
            if (w_en_wr) begin
                r_enable <= i_irq_ctrl_wdata[N_SRC-1:0];
            end
            if (w_ack) begin
                r_inservice <= r_inservice | w_claim_mask;
            end else if (w_complete) begin
                r_inservice <= '0;
            end
            if (w_claim) begin
                r_claim_id <= w_win_id;
            end else if (w_complete) begin
                r_claim_id <= '0;
            end
            r_mext <= (w_state_nxt == S_REQ);
        end
    end

    assign o_irq_ctrl_mexternal = r_mext;
    assign o_irq_ctrl_claim_id  = r_claim_id;

    always_comb begin
        o_irq_ctrl_rdata = '0;
        case (i_irq_ctrl_addr)
            2'd0: o_irq_ctrl_rdata[N_SRC-1:0] = r_pending;
            2'd1: o_irq_ctrl_rdata[N_SRC-1:0] = r_enable;
            2'd2: begin
                if (r_state == S_SERVICE) begin
                    o_irq_ctrl_rdata[ID_W-1:0] = r_claim_id;
                end
            end
            default: o_irq_ctrl_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_riscv_core_irq_ctrl.sv
// Bench for riscv_core_irq_ctrl: reference model pushes expected claims into a scoreboard,
// a monitor compares every cycle and pops a claim whenever the line rises.
module tb_riscv_core_irq_ctrl;
    localparam int N  = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  src;
    logic          wen;
    logic [1:0]    addr;
    logic [63:0]   wdata;
    logic [63:0]   rdata;
    logic          mext;
    logic          ack;
    logic [IW-1:0] claim_id;

    always #5 clk = ~clk;

    riscv_core_irq_ctrl #(.N_SRC(N), .ID_W(IW)) dut (
        .i_irq_ctrl_clk      (clk),
        .i_irq_ctrl_rst      (rst),
        .i_irq_ctrl_src      (src),
        .i_irq_ctrl_wen      (wen),
        .i_irq_ctrl_addr     (addr),
        .i_irq_ctrl_wdata    (wdata),
        .o_irq_ctrl_rdata    (rdata),
        .o_irq_ctrl_mexternal(mext),
        .i_irq_ctrl_ack      (ack),
        .o_irq_ctrl_claim_id (claim_id)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: claim==0 means nothing claimed; served means the CSR acked it.
    typedef struct {int id; int cyc;} exp_t;
    exp_t sb_q[$];
    bit m_srcq[N], m_pend[N], m_en[N], m_insv[N];
    bit o_srcq[N], o_pend[N], o_en[N], o_insv[N];
    int m_claim = 0;
    bit m_served = 0;
    bit m_acked;
    int m_cyc = 0;

    function automatic logic [63:0] m_rd(input logic [1:0] a);
        logic [63:0] r;
        r = '0;
        case (a)
            2'd0: for (int i = 0; i < N; i++) r[i] = m_pend[i];
            2'd1: for (int i = 0; i < N; i++) r[i] = m_en[i];
            2'd2: if (m_served) r = 64'(m_claim);
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_srcq[i] = 0; m_pend[i] = 0; m_en[i] = 0; m_insv[i] = 0;
            end
            m_claim  = 0;
            m_served = 0;
        end else begin
            o_srcq = m_srcq; o_pend = m_pend; o_en = m_en; o_insv = m_insv;
            m_cyc++;
            m_acked = (m_claim != 0) && !m_served && ack;
            for (int i = 0; i < N; i++) begin
                m_srcq[i] = src[i];
                m_pend[i] = (o_pend[i] || (o_srcq[i] && !o_insv[i])) &&
                            !(m_acked && (m_claim == i + 1));
            end
            if (wen && addr == 2'd1)
                for (int i = 0; i < N; i++) m_en[i] = wdata[i];
            if (m_claim == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (o_pend[i] && o_en[i] && !o_insv[i]) begin
                        m_claim = i + 1;
                        sb_q.push_back('{m_claim, m_cyc});
                        break;
                    end
                end
            end else if (!m_served) begin
                if (m_acked) begin
                    m_served = 1;
                    m_insv[m_claim - 1] = 1;
                end
            end else if (wen && addr == 2'd2 && int'(wdata[3:0]) == m_claim) begin
                m_served = 0;
                m_claim  = 0;
                for (int i = 0; i < N; i++) m_insv[i] = 0;
            end
        end
    end

    logic prev_mext = 1'b0;
    always @(posedge clk) begin
        #1;
        chk("line", 64'(mext), 64'(m_claim != 0 && !m_served));
        chk("claim_id", 64'(claim_id), 64'(m_claim));
        chk("rdata", rdata, m_rd(addr));
        if (mext === 1'b1 && prev_mext !== 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: line rose with id %0d, expected no claim", claim_id);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_id", 64'(claim_id), 64'(e.id));
                chk("sb_cycle", 64'(m_cyc), 64'(e.cyc));
            end
        end
        prev_mext = mext;
    end

    task automatic tick();
        @(negedge clk);
        wen   = 1'b0;
        ack   = 1'b0;
        wdata = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        wen = 1'b1; addr = a; wdata = d;
        tick();
    endtask

    task automatic wait_line(input int max, input bit must, output int edges);
        edges = 0;
        while (mext !== 1'b1 && edges < max) begin
            tick();
            edges++;
        end
        if (must && mext !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_line: line %0b after %0d edges, expected 1", mext, max);
        end
    endtask

    task automatic drain();
        int e;
        for (int r = 0; r < 12; r++) begin
            wait_line(8, 1'b0, e);
            if (mext !== 1'b1) break;
            ack = 1'b1;
            tick();
            wr(2'd2, 64'(claim_id));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst = 1'b1; src = '0; wen = 1'b0; addr = 2'd0; wdata = '0; ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_line", 64'(mext), 64'd0);
        chk("rst_id", 64'(claim_id), 64'd0);
        rst = 1'b0;
        tick();

        // Single source: 3-edge latency, sticky claim without ack.
        wr(2'd1, 64'hFF);
        src = 8'h04;
        wait_line(10, 1'b1, e);
        chk("lat_src", 64'(e), 64'd3);
        chk("first_id", 64'(claim_id), 64'd3);
        repeat (10) tick();
        chk("hold_line", 64'(mext), 64'd1);
        chk("hold_id", 64'(claim_id), 64'd3);

        // Ack, mismatched completion, then proper completion.
        addr = 2'd0; ack = 1'b1;
        tick();
        chk("ack_drop", 64'(mext), 64'd0);
        chk("pend2_clr", 64'(rdata[2]), 64'd0);
        addr = 2'd2; #1;
        chk("claim_rd", rdata, 64'd3);
        addr = 2'd0; repeat (3) tick();
        chk("pend2_insvc", 64'(rdata[2]), 64'd0);
        wr(2'd2, 64'd5);
        addr = 2'd2; #1;
        chk("bad_complete", rdata, 64'd3);
        wr(2'd2, 64'hABCD_0000_0000_0003);
        chk("complete_id", 64'(claim_id), 64'd0);
        wait_line(6, 1'b1, e);
        chk("repend_id", 64'(claim_id), 64'd3);
        src = '0;
        drain();

        // Two sources together: priority, then the other after completion.
        src = 8'h22;
        wait_line(10, 1'b1, e);
        chk("prio_id", 64'(claim_id), 64'd2);
        ack = 1'b1; tick();
        wen = 1'b1; addr = 2'd2; wdata = 64'd2;
        wait_line(10, 1'b1, e);
        chk("next_lat", 64'(e), 64'd2);
        chk("next_id", 64'(claim_id), 64'd6);
        src = '0;
        drain();

        // Masked source stays pending; enabling it raises the line.
        wr(2'd1, 64'h0);
        src = 8'h01;
        repeat (4) tick();
        addr = 2'd0; #1;
        chk("masked_pend", rdata, 64'h1);
        chk("masked_line", 64'(mext), 64'd0);
        wen = 1'b1; addr = 2'd1; wdata = 64'h1;
        wait_line(10, 1'b1, e);
        chk("en_lat", 64'(e), 64'd2);
        chk("en_id", 64'(claim_id), 64'd1);
        src = '0;
        drain();
        wr(2'd1, 64'h1FF);
        addr = 2'd1; #1;
        chk("en_trunc", rdata, 64'hFF);

        // Reset while in service, then restart.
        wr(2'd1, 64'h8);
        src = 8'h08;
        wait_line(10, 1'b1, e);
        ack = 1'b1; tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_line", 64'(mext), 64'd0);
        chk("arst_id", 64'(claim_id), 64'd0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a); #1;
            chk("arst_rdata", rdata, 64'd0);
        end
        tick(); tick();
        rst = 1'b0;
        wen = 1'b1; addr = 2'd1; wdata = 64'h8;
        wait_line(10, 1'b1, e);
        chk("rst_relat", 64'(e), 64'd3);
        chk("rst_reid", 64'(claim_id), 64'd4);
        src = '0;
        drain();

        // Randomized traffic.
        wr(2'd1, 64'hFF);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) src = N'($urandom);
            addr = 2'($urandom_range(0, 3));
            if (mext === 1'b1 && $urandom_range(0, 2) == 0) ack = 1'b1;
            else if ($urandom_range(0, 24) == 0) ack = 1'b1;
            if (claim_id != 0 && mext !== 1'b1 && $urandom_range(0, 3) == 0) begin
                wen = 1'b1; addr = 2'd2;
                wdata = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) wdata[3:0] = claim_id;
            end else if ($urandom_range(0, 19) == 0) begin
                wen = 1'b1; addr = 2'd1;
                wdata = {$urandom, $urandom};
            end else if ($urandom_range(0, 29) == 0) begin
                wen = 1'b1;
                addr = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3;
                wdata = {$urandom, $urandom};
            end
            tick();
        end
        src = '0;
        wr(2'd1, 64'hFF);
        drain();
        repeat (4) tick();
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
